pc_gen: RTL and testbench

Next-generation fetch PC generator. It replaces the plain PC register with three additions:
- a parametrised reset vector and redirect-channel count;
- a valid/ready instruction-bus request handshake;
- discard of in-flight fetches when a redirect arrives.

It sits at the head of the fetch stage. It drives the instruction bus and presents PC plus instruction to decode under a stall-based handshake.

---
 rtl/pc_gen_pkg.sv | 26 ++
 rtl/pc_gen_redir_arb.sv | 25 ++
 rtl/pc_gen.sv | 113 +++++++++++
 tb/tb_pc_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage types and defaults for the PC generator.
// Holds the fetch FSM state type, the redirect bundle and reset defaults.
package pc_gen_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          NREDIR_DEF   = 3;
    localparam int          STEP_DEF     = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

    // REQ     : request on the bus, waiting for acceptance
    // WAIT    : request accepted, waiting for the response
    // DISCARD : accepted request became stale, drop its response
    // HOLD    : instruction presented to decode
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic [XLEN_DEF-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect arbiter: lowest index with a valid request wins.
// Ports: valid_i/pc_i per-channel requests, any_o/tgt_o winning target.
module redir_arb #(
    parameter int NREDIR = 3,
    parameter int XLEN   = 64
) (
    input  logic [NREDIR-1:0]      valid_i,
    input  logic [NREDIR*XLEN-1:0] pc_i,
    output logic                   any_o,
    output logic [XLEN-1:0]        tgt_o
);

    // Walk from the lowest priority upward so channel 0 is written last.
    always_comb begin
        any_o = 1'b0;
        tgt_o = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                any_o = 1'b1;
                tgt_o = pc_i[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: drives the instruction bus and holds one instruction
// for decode. Ports: redirects in, ireq_* bus request, iresp_* data, out_* decode.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              NREDIR   = NREDIR_DEF,
    parameter int              STEP     = STEP_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [NREDIR-1:0]      redir_valid,
    input  logic [NREDIR*XLEN-1:0] redir_pc,
    output logic                   ireq_valid,
    output logic [XLEN-1:0]        ireq_addr,
    input  logic                   ireq_ready,
    input  logic                   iresp_valid,
    input  logic [31:0]            iresp_data,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_instr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            outv_q, outv_d;
    logic [XLEN-1:0] outpc_q, outpc_d;
    logic [31:0]     outin_q, outin_d;

    logic            redir;
    logic [XLEN-1:0] tgt;

    redir_arb #(
        .NREDIR (NREDIR),
        .XLEN   (XLEN)
    ) u_arb (
        .valid_i (redir_valid),
        .pc_i    (redir_pc),
        .any_o   (redir),
        .tgt_o   (tgt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outv_d  = outv_q;
        outpc_d = outpc_q;
        outin_d = outin_q;
        unique case (state_q)
            REQ: begin
                // A redirect may retarget an unaccepted request freely;
                // once accepted, the old request is in flight and stale.
                if (redir) begin
                    pc_d = tgt;
                    if (ireq_ready) state_d = DISCARD;
                end else if (ireq_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = iresp_valid ? REQ : DISCARD;
                end else if (iresp_valid) begin
                    outin_d = iresp_data;
                    outpc_d = pc_q;
                    outv_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            DISCARD: begin
                if (redir) pc_d = tgt;
                if (iresp_valid) state_d = REQ;
            end
            HOLD: begin
                if (redir) begin
                    outv_d  = 1'b0;
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (!stall) begin
                    outv_d  = 1'b0;
                    pc_d    = pc_q + XLEN'(STEP);
                    state_d = REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            outv_q  <= 1'b0;
            outpc_q <= '0;
            outin_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outv_q  <= outv_d;
            outpc_q <= outpc_d;
            outin_q <= outin_d;
        end
    end

    assign ireq_valid = (state_q == REQ) && !reset;
    assign ireq_addr  = pc_q;
    assign out_valid  = outv_q;
    assign out_pc     = outpc_q;
    assign out_instr  = outin_q;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios then randomized bus/redirect traffic,
// checked every cycle against a fetch-slot model.
module tb_pc_gen;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic         clk;
    logic         reset;
    logic         stall;
    logic [2:0]   redir_valid;
    logic [191:0] redir_pc;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         ireq_ready;
    logic         iresp_valid;
    logic [31:0]  iresp_data;
    logic         out_valid;
    logic [63:0]  out_pc;
    logic [31:0]  out_instr;

    pc_gen dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .ireq_ready  (ireq_ready),
        .iresp_valid (iresp_valid),
        .iresp_data  (iresp_data),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a fetch is either being offered, outstanding (maybe stale),
    // or delivered and held for decode.
    logic [63:0] m_pc;
    bit          m_inflight;
    bit          m_stale;
    bit          m_hold;
    logic [63:0] m_out_pc;
    logic [31:0] m_out_instr;
    bit          acc_prev;
    bit          auto_bus;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          rd;
        logic [63:0] tg;
        rd = 0;
        tg = '0;
        acc_prev = 0;
        if (reset) begin
            m_pc        = RST_PC;
            m_inflight  = 0;
            m_stale     = 0;
            m_hold      = 0;
            m_out_pc    = '0;
            m_out_instr = '0;
            return;
        end
        for (int i = 0; i < 3; i++)
            if (!rd && redir_valid[i]) begin
                rd = 1;
                tg = redir_pc[i*64 +: 64];
            end
        if (m_hold) begin
            if (rd) begin
                m_hold = 0;
                m_pc   = tg;
            end else if (!stall) begin
                m_hold = 0;
                m_pc   = m_pc + 64'd4;
            end
        end else if (!m_inflight) begin
            if (ireq_ready) begin
                acc_prev   = 1;
                m_inflight = 1;
                m_stale    = rd;
            end
            if (rd) m_pc = tg;
        end else begin
            if (rd) begin
                m_pc = tg;
                if (!m_stale && !iresp_valid) m_stale = 1;
                else if (iresp_valid) m_inflight = 0;
            end else if (iresp_valid) begin
                m_inflight = 0;
                if (!m_stale) begin
                    m_hold      = 1;
                    m_out_pc    = m_pc;
                    m_out_instr = iresp_data;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("ireq_valid", 64'(ireq_valid),
            64'(!reset && !m_inflight && !m_hold));
        chk("ireq_addr", ireq_addr, m_pc);
        chk("out_valid", 64'(out_valid), 64'(m_hold));
        chk("out_pc", out_pc, m_out_pc);
        chk("out_instr", 64'(out_instr), 64'(m_out_instr));
        if (auto_bus) begin
            ireq_ready  = 1'b1;
            iresp_valid = acc_prev;
            iresp_data  = $urandom;
        end
    endtask

    task automatic wait_out(input int lim);
        for (int k = 0; k < lim; k++) begin
            cyc();
            if (out_valid) break;
        end
        chk("wait_out", 64'(out_valid), 64'd1);
    endtask

    task automatic clr_in();
        redir_valid = '0;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        stall       = 1'b0;
    endtask

    logic [63:0] hpc;
    logic [31:0] hin;

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redir_valid = '0;
        redir_pc    = '0;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        iresp_data  = '0;
        auto_bus    = 0;
        m_pc        = '0;
        m_inflight  = 0;
        m_stale     = 0;
        m_hold      = 0;
        m_out_pc    = '0;
        m_out_instr = '0;

        // Reset state
        cyc();
        chk("rst_addr", ireq_addr, RST_PC);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_opc", out_pc, 64'd0);
        chk("rst_ireq", 64'(ireq_valid), 64'd0);
        reset = 1'b0;

        // Sequential fetch with an always-ready, 1-cycle bus
        auto_bus   = 1;
        ireq_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_out(10);
            chk("seq_pc", out_pc, RST_PC + 64'(4 * k));
            chk("seq_instr", 64'(out_instr), 64'(m_out_instr));
            if (k == 2) stall = 1'b1;
        end

        // Stall in HOLD keeps everything stable
        hpc = out_pc;
        hin = out_instr;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_ov", 64'(out_valid), 64'd1);
            chk("stall_pc", out_pc, hpc);
            chk("stall_in", 64'(out_instr), 64'(hin));
            chk("stall_req", 64'(ireq_valid), 64'd0);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_req", 64'(ireq_valid), 64'd1);
        chk("unstall_addr", ireq_addr, hpc + 64'd4);

        // Redirect (channel 2) while waiting: response dropped
        cyc();
        auto_bus    = 0;
        clr_in();
        redir_valid = 3'b100;
        redir_pc[128 +: 64] = 64'h8000_1000;
        cyc();
        clr_in();
        iresp_valid = 1'b1;
        iresp_data  = 32'hdead_beef;
        cyc();
        chk("wait_redir_ov", 64'(out_valid), 64'd0);
        chk("wait_redir_req", 64'(ireq_valid), 64'd1);
        chk("wait_redir_addr", ireq_addr, 64'h8000_1000);

        // All three channels at once: channel 0 wins
        clr_in();
        redir_valid = 3'b111;
        redir_pc    = {64'hCCCC_0000, 64'hBBBB_0000, 64'hAAAA_0000};
        cyc();
        chk("prio_addr", ireq_addr, 64'hAAAA_0000);

        // Redirect on acceptance: stale response dropped
        clr_in();
        redir_valid = 3'b010;
        redir_pc[64 +: 64] = 64'h2000_0040;
        ireq_ready  = 1'b1;
        cyc();
        chk("disc_req", 64'(ireq_valid), 64'd0);
        clr_in();
        iresp_valid = 1'b1;
        cyc();
        chk("disc_ov", 64'(out_valid), 64'd0);
        chk("disc_addr", ireq_addr, 64'h2000_0040);
        clr_in();
        ireq_ready = 1'b1;
        cyc();
        clr_in();
        iresp_valid = 1'b1;
        redir_valid = 3'b001;
        redir_pc[0 +: 64] = 64'h3000_0100;
        cyc();
        chk("wr_req", 64'(ireq_valid), 64'd1);
        chk("wr_addr", ireq_addr, 64'h3000_0100);
        chk("wr_ov", 64'(out_valid), 64'd0);

        // PC wraps to zero
        clr_in();
        redir_valid = 3'b001;
        redir_pc[0 +: 64] = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        clr_in();
        ireq_ready = 1'b1;
        cyc();
        clr_in();
        iresp_valid = 1'b1;
        iresp_data  = 32'h0000_0013;
        cyc();
        chk("wrap_opc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_oin", 64'(out_instr), 64'h13);
        clr_in();
        cyc();
        chk("wrap_addr", ireq_addr, 64'd0);

        // Reset during WAIT
        ireq_ready = 1'b1;
        cyc();
        clr_in();
        reset = 1'b1;
        cyc();
        chk("rstw_addr", ireq_addr, RST_PC);
        chk("rstw_ov", 64'(out_valid), 64'd0);
        reset = 1'b0;
        cyc();
        chk("rstw_req", 64'(ireq_valid), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stall       = $urandom_range(0, 1) == 1;
            ireq_ready  = $urandom_range(0, 1) == 1;
            iresp_valid = $urandom_range(0, 1) == 1;
            iresp_data  = $urandom;
            for (int i = 0; i < 3; i++) begin
                redir_valid[i] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0)
                    redir_pc[i*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFC;
                else
                    redir_pc[i*64 +: 64] = {$urandom, $urandom};
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
